signal_delay_line: RTL

SIGNAL_DELAY_LINE -- requirements
Module: signal_delay_line

---
 rtl/signal_delay_line_if.sv | 27 ++
 rtl/signal_delay_line.sv | 82 ++++++++
 2 files changed

// File: rtl/signal_delay_line_if.sv
// Handshake/bus signals of the runtime-tapped delay line, grouped for port connection.
// The master drives the controls and the sample stream. The slave (the delay line) returns the tapped output and the occupancy count.
interface signal_delay_line_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 4
);
  localparam int SEL_W = $clog2(MAX_DELAY + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] delay_sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] pending;

  modport master (
    output en, flush, in_valid, in_data, delay_sel,
    input  out_valid, out_data, pending
  );

  modport slave (
    input  en, flush, in_valid, in_data, delay_sel,
    output out_valid, out_data, pending
  );
endinterface

// File: rtl/signal_delay_line.sv
// Delay line of MAX_DELAY registered stages. Each stage holds a valid bit and a data word.
// The output tap is selected at runtime, and the block also reports how many stages hold a valid sample.
module signal_delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst,
  signal_delay_line_if.slave bus
);
  localparam int SEL_W = $clog2(MAX_DELAY + 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("signal_delay_line: WIDTH must be in 1..64");
  end
  if (MAX_DELAY < 1 || MAX_DELAY > 32) begin : g_bad_depth
    $error("signal_delay_line: MAX_DELAY must be in 1..32");
  end

  logic [MAX_DELAY-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [WIDTH-1:0]     data_d [MAX_DELAY];
  logic [SEL_W-1:0]     pending_q, pending_d;
  logic [SEL_W-1:0]     eff_sel;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    pending_d = pending_q;
    if (bus.flush) begin
      valid_d   = '0;
      pending_d = '0;
    end else if (bus.en) begin
      valid_d[0] = bus.in_valid;
      data_d[0]  = bus.in_data;
      for (int i = 1; i < MAX_DELAY; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      // The oldest stage drops out as the new sample enters, so the count stays within 0..MAX_DELAY.
      pending_d = pending_q + SEL_W'(bus.in_valid) - SEL_W'(valid_q[MAX_DELAY-1]);
    end
  end

  // NOTE: the data words are reset along with the valid bits, so no stale payload is visible after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < MAX_DELAY; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its neighbour's pre-edge value.
      valid_q   <= valid_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign eff_sel = (bus.delay_sel > SEL_W'(MAX_DELAY)) ? SEL_W'(MAX_DELAY) : bus.delay_sel;

  // A tap of 0 passes the input straight through. A tap of d reads stage d-1.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    if (!rst) begin
      if (eff_sel == '0) begin
        bus.out_valid = bus.in_valid;
        bus.out_data  = bus.in_data;
      end else begin
        for (int i = 0; i < MAX_DELAY; i++) begin
          if (eff_sel == SEL_W'(i + 1)) begin
            bus.out_valid = valid_q[i];
            bus.out_data  = data_q[i];
          end
        end
      end
    end
  end

  assign bus.pending = pending_q;
endmodule
